// File: rtl/uart_tx_fifo_cfg_if.sv
// Push-port bundle for the UART transmitter FIFO.
//   p_data      word to transmit
//   data_valid  push request from the host
//   data_ready  FIFO has room; a push happens on the clock edge when valid && ready
// The host side uses the master modport, the transmitter uses the slave modport.
interface uart_tx_fifo_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output p_data, output data_valid, input data_ready);
    modport slave  (input p_data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small TX FIFO, internal baud prescaler and
// per-frame parity / stop-bit configuration.  Frames are sent back-to-back
// while the FIFO holds data.
// Ports:
//   CLK, rst      clock, asynchronous active-high reset
//   push_if       valid/ready push port (p_data, data_valid, data_ready)
//   par_en        append a parity bit
//   par_typ       0 = even parity, 1 = odd parity
//   stop2         two stop bits instead of one
//   baud_div      bit period = baud_div+1 clock cycles
//   send_brk      hold the line low (only when UART_TX_BREAK_EN is defined)
//   tx_out        serial line, idles high
//   busy          a frame (or break) is on the line
//   fifo_level    words currently stored in the FIFO
// Optional feature: define UART_TX_BREAK_EN to add send_brk and the BREAK state.
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO word (or a break request)
// LOAD   | head word latched, start bit begins on the next edge
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits (high); next frame decided at the last tick
// BREAK  | line held low while send_brk is high
module uart_tx_fifo_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          rst,
    uart_tx_fifo_cfg_if.slave             push_if,
    input  logic                          par_en,
    input  logic                          par_typ,
    input  logic                          stop2,
    input  logic [DIV_WIDTH-1:0]          baud_div,
`ifdef UART_TX_BREAK_EN
    input  logic                          send_brk,
`endif
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
`ifdef UART_TX_BREAK_EN
        BREAK,
`endif
        STOP
    } state_t;

    // FIFO
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           level_q;
    logic                  push, pop, fifo_nempty;

    // frame registers
    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  second_q, second_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic                  tick;

    assign push_if.data_ready = (level_q != LEVEL_FULL);
    assign push        = push_if.data_valid && push_if.data_ready;
    assign fifo_nempty = (level_q != '0);
    assign fifo_level  = level_q;
    assign tick        = (cnt_q == div_q);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_if.p_data;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            second_q  <= 1'b0;
            word_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            second_q  <= second_d;
            word_q    <= word_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        idx_d     = idx_q;
        second_d  = second_q;
        word_d    = word_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        pop       = 1'b0;
        tx_out    = 1'b1;
        busy      = 1'b1;

        // Prescaler runs only while something is on the line; IDLE/LOAD keep it at 0.
        if (state_q != IDLE && state_q != LOAD) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                busy = 1'b0;
`ifdef UART_TX_BREAK_EN
                if (send_brk) begin
                    state_d = BREAK;
                    div_d   = baud_div;
                end else
`endif
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b0;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                tx_out = 1'b0;
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                tx_out = word_q[idx_q];
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = par_en_q ? PARITY : STOP;
                        second_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                tx_out = ^word_q ^ par_typ_q;
                if (tick) begin
                    state_d  = STOP;
                    second_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop2_q && !second_q) begin
                        second_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                    end else if (send_brk) begin
                        state_d = BREAK;
                        div_d   = baud_div;
`endif
                    end else if (fifo_nempty) begin
                        // Chain straight into the next start bit, no idle cycle.
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                tx_out = 1'b0;
                if (tick && !send_brk) begin
                    // Exactly one stop period follows a break, whatever stop2 says.
                    state_d  = STOP;
                    second_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Frame configuration is captured together with the word.
        if (pop) begin
            word_d    = mem_q[rd_ptr_q];
            par_en_d  = par_en;
            par_typ_d = par_typ;
            stop2_d   = stop2;
            div_d     = baud_div;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
module tb_uart_tx_fifo_cfg;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;
    localparam int MAXC  = 512;

    logic            CLK = 1'b0;
    logic            rst = 1'b1;
    logic            par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
    logic [DIVW-1:0] baud_div = '0;
    logic            tx_out, busy;
    logic [2:0]      fifo_level;
`ifdef UART_TX_BREAK_EN
    logic            send_brk = 1'b0;
`endif

    uart_tx_fifo_cfg_if #(.DATA_WIDTH(DW)) pif ();

    uart_tx_fifo_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .push_if    (pif),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .baud_div   (baud_div),
`ifdef UART_TX_BREAK_EN
        .send_brk   (send_brk),
`endif
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // per-cycle stimulus (applied at edge c) and observations (sampled after edge c)
    int              n_cyc;
    int              n_acc;
    logic            v_a  [MAXC];
    logic [DW-1:0]   d_a  [MAXC];
    logic            pe_a [MAXC], pt_a [MAXC], s2_a [MAXC];
    logic [DIVW-1:0] bd_a [MAXC];
    logic            o_tx [MAXC], o_busy [MAXC], o_rdy [MAXC];
    logic [2:0]      o_lvl [MAXC];
    logic            e_tx [MAXC], e_busy [MAXC], e_rdy [MAXC];
    int              e_lvl [MAXC];

    task automatic clear_stim(input logic [DIVW-1:0] bd, input logic pe, input logic pt, input logic s2);
        for (int c = 0; c < MAXC; c++) begin
            v_a[c] = 1'b0; d_a[c] = '0;
            pe_a[c] = pe; pt_a[c] = pt; s2_a[c] = s2; bd_a[c] = bd;
        end
    endtask

    task automatic do_reset();
        pif.data_valid = 1'b0;
        @(negedge CLK); rst = 1'b1;
        @(negedge CLK); rst = 1'b0;
    endtask

    task automatic run(input int n);
        n_cyc = n;
        for (int c = 1; c <= n; c++) begin
            @(negedge CLK);
            pif.data_valid = v_a[c];
            pif.p_data     = d_a[c];
            par_en         = pe_a[c];
            par_typ        = pt_a[c];
            stop2          = s2_a[c];
            baud_div       = bd_a[c];
            @(posedge CLK); #1;
            o_tx[c] = tx_out; o_busy[c] = busy; o_rdy[c] = pif.data_ready; o_lvl[c] = fifo_level;
        end
        @(negedge CLK);
        pif.data_valid = 1'b0;
    endtask

    // Reference: a word queue plus a list of frames placed on a time line.
    // A frame starts at the end of the previous one if a word was waiting during
    // its last stop cycle, otherwise two edges after the word arrived.
    task automatic model_build();
        logic [DW-1:0] q[$];
        logic [DW-1:0] w;
        int lvl, last_end, st, per, nb, b;
        bit had;
        logic bv;
        lvl = 0; last_end = 0; had = 0; n_acc = 0;
        for (int t = 0; t < MAXC; t++) begin
            e_tx[t] = 1'b1; e_busy[t] = 1'b0; e_rdy[t] = 1'b1; e_lvl[t] = 0;
        end
        for (int t = 1; t <= n_cyc; t++) begin
            st = -1;
            if (q.size() != 0) begin
                if (had && t == last_end) st = t;
                else if (t - 1 >= last_end) st = t + 1;
            end
            if (st >= 0) begin
                w   = q.pop_front();
                per = int'(bd_a[t]) + 1;
                nb  = 2 + DW + int'(pe_a[t]) + int'(s2_a[t]);
                for (int k = 0; k < per * nb; k++) begin
                    if (st + k < MAXC) begin
                        b = k / per;
                        if (b == 0) bv = 1'b0;
                        else if (b <= DW) bv = w[b-1];
                        else if (b == DW + 1 && pe_a[t]) bv = ^w ^ pt_a[t];
                        else bv = 1'b1;
                        e_tx[st+k] = bv; e_busy[st+k] = 1'b1;
                    end
                end
                last_end = st + per * nb;
                had = 1;
            end
            if (v_a[t] && lvl != DEPTH) begin
                q.push_back(d_a[t]);
                n_acc++;
            end
            lvl = q.size();
            e_lvl[t] = lvl;
            e_rdy[t] = (lvl != DEPTH);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({tx_out, busy, pif.data_ready, fifo_level} !== 6'b101_000) begin
            n_err++;
            $display("FAIL reset_async got tx/busy/rdy/lvl=%b want 101000", {tx_out, busy, pif.data_ready, fifo_level});
        end
        @(negedge CLK); rst = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({tx_out, busy, pif.data_ready, fifo_level} !== 6'b101_000) begin
            n_err++;
            $display("FAIL reset_idle got tx/busy/rdy/lvl=%b want 101000", {tx_out, busy, pif.data_ready, fifo_level});
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0] seq;
        int bcnt;
        seq = 10'b1101001010;
        do_reset();
        clear_stim(16'd3, 1'b0, 1'b0, 1'b0);
        v_a[1] = 1'b1; d_a[1] = 8'hA5;
        run(50);
        model_build();
        for (int t = 1; t <= n_cyc; t++) begin
            n_cmp++;
            if ({o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]} !== {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])}) begin
                n_err++;
                $display("FAIL basic_trace cycle %0d got %b want %b", t,
                         {o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]}, {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])});
            end
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                n_cmp++;
                if (o_tx[3 + 4*k + j] !== seq[k]) begin
                    n_err++;
                    $display("FAIL basic_bit %0d got %b want %b", k, o_tx[3 + 4*k + j], seq[k]);
                end
            end
        end
        bcnt = 0;
        for (int t = 1; t <= n_cyc; t++) if (o_busy[t]) bcnt++;
        n_cmp++;
        if (bcnt != 40) begin
            n_err++;
            $display("FAIL basic_busy_len got %0d want 40", bcnt);
        end
    endtask

    task automatic test_parity();
        int bcnt;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            clear_stim(16'd3, 1'b1, p[0], 1'b0);
            v_a[1] = 1'b1; d_a[1] = 8'hA5;
            run(54);
            model_build();
            for (int t = 1; t <= n_cyc; t++) begin
                n_cmp++;
                if ({o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]} !== {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])}) begin
                    n_err++;
                    $display("FAIL parity_trace typ %0d cycle %0d got %b want %b", p, t,
                             {o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]}, {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])});
                end
            end
            n_cmp++;
            if (o_tx[39] !== p[0]) begin
                n_err++;
                $display("FAIL parity_bit typ %0d got %b want %b", p, o_tx[39], p[0]);
            end
            bcnt = 0;
            for (int t = 1; t <= n_cyc; t++) if (o_busy[t]) bcnt++;
            n_cmp++;
            if (bcnt != 44) begin
                n_err++;
                $display("FAIL parity_frame_len typ %0d got %0d want 44", p, bcnt);
            end
        end
    endtask

    task automatic test_fifo_full();
        int acc;
        do_reset();
        clear_stim(16'd15, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            v_a[c] = 1'b1; d_a[c] = 8'($urandom);
        end
        run(30);
        model_build();
        for (int t = 1; t <= n_cyc; t++) begin
            n_cmp++;
            if ({o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]} !== {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])}) begin
                n_err++;
                $display("FAIL full_trace cycle %0d got %b want %b", t,
                         {o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]}, {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])});
            end
        end
        acc = 0;
        for (int c = 1; c <= 6; c++) if (v_a[c] && (c == 1 || o_rdy[c-1])) acc++;
        n_cmp++;
        if (acc != 5) begin
            n_err++;
            $display("FAIL full_accepted got %0d want 5", acc);
        end
        n_cmp++;
        if ({o_rdy[5], o_lvl[6]} !== {1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL full_ready_level got rdy=%b lvl=%0d want rdy=0 lvl=4", o_rdy[5], o_lvl[6]);
        end
    endtask

    task automatic test_back_to_back();
        int bcnt;
        do_reset();
        clear_stim(16'd0, 1'b0, 1'b0, 1'b1);
        v_a[1] = 1'b1; d_a[1] = 8'h3C;
        v_a[2] = 1'b1; d_a[2] = 8'hFF;
        run(30);
        model_build();
        for (int t = 1; t <= n_cyc; t++) begin
            n_cmp++;
            if ({o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]} !== {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])}) begin
                n_err++;
                $display("FAIL b2b_trace cycle %0d got %b want %b", t,
                         {o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]}, {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])});
            end
        end
        n_cmp++;
        if ({o_tx[12], o_tx[13], o_tx[14]} !== 3'b110) begin
            n_err++;
            $display("FAIL b2b_boundary got %b want 110", {o_tx[12], o_tx[13], o_tx[14]});
        end
        bcnt = 0;
        for (int t = 3; t <= 24; t++) if (o_busy[t]) bcnt++;
        n_cmp++;
        if (bcnt != 22) begin
            n_err++;
            $display("FAIL b2b_busy got %0d want 22", bcnt);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            clear_stim(16'd0, 1'b0, 1'b0, 1'b0);
            for (int c = 1; c <= 420; c++) begin
                v_a[c]  = (c <= 220) && ($urandom_range(0, 99) < 60);
                d_a[c]  = 8'($urandom);
                bd_a[c] = 16'($urandom_range(0, 2));
                pe_a[c] = 1'($urandom);
                pt_a[c] = 1'($urandom);
                s2_a[c] = 1'($urandom);
            end
            run(420);
            model_build();
            for (int t = 1; t <= n_cyc; t++) begin
                n_cmp++;
                if ({o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]} !== {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])}) begin
                    n_err++;
                    $display("FAIL random_trace round %0d cycle %0d got %b want %b", r, t,
                             {o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]}, {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])});
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        clear_stim(16'd3, 1'b0, 1'b0, 1'b0);
        v_a[1] = 1'b1; d_a[1] = 8'hF0;
        v_a[2] = 1'b1; d_a[2] = 8'h3C;
        v_a[3] = 1'b1; d_a[3] = 8'h81;
        run(20);
        model_build();
        for (int t = 1; t <= n_cyc; t++) begin
            n_cmp++;
            if ({o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]} !== {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])}) begin
                n_err++;
                $display("FAIL midrst_trace cycle %0d got %b want %b", t,
                         {o_tx[t], o_busy[t], o_rdy[t], o_lvl[t]}, {e_tx[t], e_busy[t], e_rdy[t], 3'(e_lvl[t])});
            end
        end
        // now one cycle past edge 20: data bit 3 of 8'hF0 (low), two words waiting
        n_cmp++;
        if ({tx_out, busy, fifo_level} !== 5'b01_010) begin
            n_err++;
            $display("FAIL midrst_before got tx/busy/lvl=%b want 01010", {tx_out, busy, fifo_level});
        end
        #2; rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_out, busy, pif.data_ready, fifo_level} !== 6'b101_000) begin
            n_err++;
            $display("FAIL midrst_immediate got tx/busy/rdy/lvl=%b want 101000", {tx_out, busy, pif.data_ready, fifo_level});
        end
        @(negedge CLK); @(negedge CLK); rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if ({tx_out, busy, fifo_level} !== 5'b10_000) begin
                n_err++;
                $display("FAIL midrst_after cycle %0d got tx/busy/lvl=%b want 10000", c, {tx_out, busy, fifo_level});
            end
        end
    endtask

    initial begin
        pif.data_valid = 1'b0;
        pif.p_data     = '0;
        test_reset();
        test_basic_frame();
        test_parity();
        test_fifo_full();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
